// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types for the pipeline hazard controller.
package hazard_pkg;
  localparam int REG_AW = 5;
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;
  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    FREEZE   = 2'b10
  } hz_state_e;
endpackage

// File: rtl/fwd_sel_gen.sv
// fwd_sel_gen: forwarding select for one ID source; the newer EX producer beats MEM.
module fwd_sel_gen #(
  parameter int AW = 5
) (
  input  logic [AW-1:0] i_rs_addr,
  input  logic          i_rs_used,
  input  logic [AW-1:0] i_ex_rd_addr,
  input  logic          i_ex_rd_wren,
  input  logic [AW-1:0] i_mem_rd_addr,
  input  logic          i_mem_rd_wren,
  output logic [1:0]    o_sel,
  output logic          o_ex_hit
);
  import hazard_pkg::*;
  logic used, ex_m, mem_m;
  assign used     = i_rs_used & (i_rs_addr != '0);
  assign ex_m     = used & i_ex_rd_wren & (i_ex_rd_addr == i_rs_addr);
  assign mem_m    = used & i_mem_rd_wren & (i_mem_rd_addr == i_rs_addr);
  assign o_ex_hit = ex_m;
  assign o_sel    = ex_m ? FWD_MEM : mem_m ? FWD_WB : FWD_RF;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding selects, load-use stall, branch flush and dmem freeze.
// Performance counters are built only with HAZARD_PERF_EN defined.
module hazard_ctrl #(
  parameter int REG_AW = hazard_pkg::REG_AW,
  parameter int CNT_W  = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [REG_AW-1:0] i_id_rs1_addr,
  input  logic [REG_AW-1:0] i_id_rs2_addr,
  input  logic              i_id_rs1_used,
  input  logic              i_id_rs2_used,
  input  logic [REG_AW-1:0] i_ex_rd_addr,
  input  logic              i_ex_rd_wren,
  input  logic              i_ex_is_load,
  input  logic [REG_AW-1:0] i_mem_rd_addr,
  input  logic              i_mem_rd_wren,
  input  logic              i_ex_br_taken,
  input  logic              i_dmem_busy,
  output logic [1:0]        o_forward_a,
  output logic [1:0]        o_forward_b,
  output logic              o_pc_en,
  output logic              o_if_id_en,
  output logic              o_id_ex_en,
  output logic              o_if_id_flush,
  output logic              o_id_ex_flush,
  output logic [CNT_W-1:0]  o_stall_cnt,
  output logic [CNT_W-1:0]  o_flush_cnt
);
  import hazard_pkg::*;
  hz_state_e state_q, state_d;
  logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d, sel_a, sel_b;
  logic hit_a, hit_b, frz, br, lu;
  fwd_sel_gen #(.AW(REG_AW)) u_fwd_a (
    .i_rs_addr(i_id_rs1_addr), .i_rs_used(i_id_rs1_used),
    .i_ex_rd_addr(i_ex_rd_addr), .i_ex_rd_wren(i_ex_rd_wren),
    .i_mem_rd_addr(i_mem_rd_addr), .i_mem_rd_wren(i_mem_rd_wren),
    .o_sel(sel_a), .o_ex_hit(hit_a)
  );
  fwd_sel_gen #(.AW(REG_AW)) u_fwd_b (
    .i_rs_addr(i_id_rs2_addr), .i_rs_used(i_id_rs2_used),
    .i_ex_rd_addr(i_ex_rd_addr), .i_ex_rd_wren(i_ex_rd_wren),
    .i_mem_rd_addr(i_mem_rd_addr), .i_mem_rd_wren(i_mem_rd_wren),
    .o_sel(sel_b), .o_ex_hit(hit_b)
  );
  // Freeze beats branch beats load-use; the stall cycle itself never re-detects.
  assign frz = i_dmem_busy;
  assign br  = ~frz & i_ex_br_taken;
  assign lu  = ~frz & ~br & (state_q != LU_STALL) & i_ex_is_load & (hit_a | hit_b);
  assign o_pc_en       = i_rst_n & ~frz & ~lu;
  assign o_if_id_en    = i_rst_n & ~frz & ~lu;
  assign o_id_ex_en    = i_rst_n & ~frz;
  assign o_if_id_flush = ~i_rst_n | br;
  assign o_id_ex_flush = ~i_rst_n | br | lu;
  assign o_forward_a   = fwd_a_q;
  assign o_forward_b   = fwd_b_q;
  always_comb begin
    state_d = frz ? FREEZE : lu ? LU_STALL : RUN;
    fwd_a_d = o_id_ex_flush ? FWD_RF : o_id_ex_en ? sel_a : fwd_a_q;
    fwd_b_d = o_id_ex_flush ? FWD_RF : o_id_ex_en ? sel_b : fwd_b_q;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= RUN;
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else begin
      state_q <= state_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end
`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_q, flush_q;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!o_pc_en && !(&stall_q)) stall_q <= stall_q + CNT_W'(1);
      if (br && !(&flush_q)) flush_q <= flush_q + CNT_W'(1);
    end
  end
  assign o_stall_cnt = stall_q;
  assign o_flush_cnt = flush_q;
`else
  assign o_stall_cnt = '0;
  assign o_flush_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table-driven check of hazard_ctrl plus freeze and reset sequences.
module tb_hazard_ctrl;
  logic i_clk = 1'b0, i_rst_n;
  logic [4:0] i_id_rs1_addr, i_id_rs2_addr, i_ex_rd_addr, i_mem_rd_addr;
  logic i_id_rs1_used, i_id_rs2_used, i_ex_rd_wren, i_ex_is_load, i_mem_rd_wren;
  logic i_ex_br_taken, i_dmem_busy;
  logic [1:0] o_forward_a, o_forward_b;
  logic o_pc_en, o_if_id_en, o_id_ex_en, o_if_id_flush, o_id_ex_flush;
  logic [31:0] o_stall_cnt, o_flush_cnt;
  int n_chk = 0, n_bad = 0;
  int m_st = 0, m_fl = 0;
  hazard_ctrl dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_id_rs1_addr(i_id_rs1_addr), .i_id_rs2_addr(i_id_rs2_addr),
    .i_id_rs1_used(i_id_rs1_used), .i_id_rs2_used(i_id_rs2_used),
    .i_ex_rd_addr(i_ex_rd_addr), .i_ex_rd_wren(i_ex_rd_wren), .i_ex_is_load(i_ex_is_load),
    .i_mem_rd_addr(i_mem_rd_addr), .i_mem_rd_wren(i_mem_rd_wren),
    .i_ex_br_taken(i_ex_br_taken), .i_dmem_busy(i_dmem_busy),
    .o_forward_a(o_forward_a), .o_forward_b(o_forward_b),
    .o_pc_en(o_pc_en), .o_if_id_en(o_if_id_en), .o_id_ex_en(o_id_ex_en),
    .o_if_id_flush(o_if_id_flush), .o_id_ex_flush(o_id_ex_flush),
    .o_stall_cnt(o_stall_cnt), .o_flush_cnt(o_flush_cnt)
  );
  always #5 i_clk = ~i_clk;
  typedef struct {
    logic [4:0] rs1, rs2;
    logic u1, u2;
    logic [4:0] exrd;
    logic exw, exld;
    logic [4:0] memrd;
    logic memw, br, busy;
    logic [2:0] en;
    logic [1:0] fl, fa, fb;
  } vec_t;
  vec_t vt[12];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask
  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                       input logic [4:0] exrd, input logic exw, input logic exld,
                       input logic [4:0] memrd, input logic memw, input logic br, input logic busy);
    i_id_rs1_addr = rs1; i_id_rs2_addr = rs2; i_id_rs1_used = u1; i_id_rs2_used = u2;
    i_ex_rd_addr = exrd; i_ex_rd_wren = exw; i_ex_is_load = exld;
    i_mem_rd_addr = memrd; i_mem_rd_wren = memw; i_ex_br_taken = br; i_dmem_busy = busy;
  endtask
  // Checks this cycle's enables/flushes, clocks once, then checks selects and counters.
  task automatic step(input string nm, input logic [2:0] en, input logic [1:0] fl,
                      input logic [1:0] fa, input logic [1:0] fb);
    #3;
    chk({nm, ".en"}, {29'd0, o_pc_en, o_if_id_en, o_id_ex_en}, {29'd0, en});
    chk({nm, ".flush"}, {30'd0, o_if_id_flush, o_id_ex_flush}, {30'd0, fl});
`ifdef HAZARD_PERF_EN
    if (!i_rst_n) begin m_st = 0; m_fl = 0; end
    else begin m_st += int'(!en[2]); m_fl += int'(fl[1]); end
`endif
    @(posedge i_clk);
    #1;
    chk({nm, ".fwd_a"}, {30'd0, o_forward_a}, {30'd0, fa});
    chk({nm, ".fwd_b"}, {30'd0, o_forward_b}, {30'd0, fb});
    chk({nm, ".stall_cnt"}, o_stall_cnt, m_st);
    chk({nm, ".flush_cnt"}, o_flush_cnt, m_fl);
  endtask
  initial begin
    vt[0]  = '{1, 5, 1, 1,  5, 1, 0, 0, 0, 0, 0, 3'b111, 2'b00, 2'b00, 2'b01};
    vt[1]  = '{2, 9, 1, 1,  4, 1, 0, 2, 1, 0, 0, 3'b111, 2'b00, 2'b10, 2'b00};
    vt[2]  = '{3, 3, 1, 0,  3, 1, 0, 3, 1, 0, 0, 3'b111, 2'b00, 2'b01, 2'b00};
    vt[3]  = '{0, 0, 1, 1,  0, 1, 1, 0, 1, 0, 0, 3'b111, 2'b00, 2'b00, 2'b00};
    vt[4]  = '{6, 8, 0, 1,  6, 1, 1, 8, 0, 0, 0, 3'b111, 2'b00, 2'b00, 2'b00};
    vt[5]  = '{7, 1, 1, 1,  7, 1, 1, 0, 0, 0, 0, 3'b001, 2'b01, 2'b00, 2'b00};
    vt[6]  = '{7, 1, 1, 1,  0, 0, 0, 7, 1, 0, 0, 3'b111, 2'b00, 2'b10, 2'b00};
    vt[7]  = '{3, 12, 1, 1, 12, 1, 1, 3, 1, 0, 0, 3'b001, 2'b01, 2'b00, 2'b00};
    vt[8]  = '{3, 12, 1, 1, 12, 1, 1, 3, 1, 0, 0, 3'b111, 2'b00, 2'b10, 2'b01};
    vt[9]  = '{7, 2, 1, 1,  7, 1, 1, 0, 0, 1, 0, 3'b111, 2'b11, 2'b00, 2'b00};
    vt[10] = '{5, 6, 1, 1,  5, 1, 0, 6, 1, 0, 0, 3'b111, 2'b00, 2'b01, 2'b10};
    vt[11] = '{9, 0, 1, 0,  9, 0, 1, 9, 1, 0, 0, 3'b111, 2'b00, 2'b10, 2'b00};
    i_rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("rst0", 3'b000, 2'b11, 2'b00, 2'b00);
    step("rst1", 3'b000, 2'b11, 2'b00, 2'b00);
    i_rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(vt[i].rs1, vt[i].rs2, vt[i].u1, vt[i].u2, vt[i].exrd, vt[i].exw, vt[i].exld,
            vt[i].memrd, vt[i].memw, vt[i].br, vt[i].busy);
      step($sformatf("vec%0d", i), vt[i].en, vt[i].fl, vt[i].fa, vt[i].fb);
    end
    for (int i = 0; i < 3; i++) begin
      drive(4, 0, 1, 0, 4, 1, 0, 2, 1, 1, 1);
      step($sformatf("freeze%0d", i), 3'b000, 2'b00, 2'b10, 2'b00);
    end
    drive(4, 0, 1, 0, 4, 1, 0, 2, 1, 1, 0);
    step("freeze_exit", 3'b111, 2'b11, 2'b00, 2'b00);
    drive(7, 1, 1, 1, 7, 1, 1, 0, 0, 0, 0);
    step("lu_pre_rst", 3'b001, 2'b01, 2'b00, 2'b00);
    i_rst_n = 1'b0;
    step("rst_in_lu0", 3'b000, 2'b11, 2'b00, 2'b00);
    step("rst_in_lu1", 3'b000, 2'b11, 2'b00, 2'b00);
    i_rst_n = 1'b1;
    step("post_rst_lu", 3'b001, 2'b01, 2'b00, 2'b00);
    drive(7, 1, 1, 1, 0, 0, 0, 7, 1, 0, 0);
    step("post_rst_stall", 3'b111, 2'b00, 2'b10, 2'b00);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
